id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Operand-fetch stage and ID/EX pipeline register for each MIPS core; sits directly downstream of regfile.
//  Drives regfile read addresses and takes its read data. Forwards from EX/MEM and MEM/WB.
//  Detects load-use hazards and stalls IF/ID. Registers operands and control for the EX stage.
// PARAMETERS
//  DATA_W  8   datapath width (matches regfile)
//  REG_AW  5   register index width
//  CTRL_W  6   opaque EX/MEM/WB control bundle width
//  CNT_W   16  stall performance counter width
// PORTS
//  clk             in  1       rising-edge clock
//  reset           in  1       synchronous, active-high reset
//  in_valid        in  1       IF/ID holds a valid instruction
//  in_rs,in_rt     in  REG_AW  source register indices
//  in_rd           in  REG_AW  destination index
//  in_imm          in  DATA_W  immediate
//  in_ctrl         in  CTRL_W  control bundle, passed through
//  in_is_load      in  1       instruction is a load
//  in_reg_write    in  1       instruction writes rd
//  rf_read_reg1/2  out REG_AW  combinational: in_rs / in_rt
//  rf_read_data1/2 in  DATA_W  regfile read data
//  exmem_reg_write,exmem_rd,exmem_data  in 1/REG_AW/DATA_W  EX/MEM producer
//  memwb_reg_write,memwb_rd,memwb_data  in 1/REG_AW/DATA_W  MEM/WB producer (also the regfile write port)
//  flush           in  1       kill the instruction entering ID/EX this cycle
//  stall_out       out 1       combinational: hold PC and IF/ID
//  out_valid,out_a,out_b,out_imm,out_rd,out_ctrl,out_is_load,out_reg_write  out  ID/EX register
//  stall_count     out CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1): all out_* = 0, stall_count = 0. stall_out reads 0 while reset=1.
//  - Latency: 1 cycle in_* -> out_*. The register updates every cycle; there is no enable.
//  - Operand select, per source s (rs->a, rt->b):
//    * EX/MEM if exmem_reg_write && exmem_rd==s && s!=0
//    * else MEM/WB if memwb_reg_write && memwb_rd==s && s!=0
//    * else rf_read_dataN
//    * s==0 always yields 0, regardless of forwarding state.
//  - MEM/WB forwarding also covers the regfile's write-then-read lag.
//  - Load-use hazard: hz = in_valid && out_valid && out_is_load && out_reg_write && out_rd!=0
//    && (out_rd==in_rs || out_rd==in_rt).
//  - stall_out = hz && !flush && !reset.
//  - When stall_out=1: next out_valid=0 (bubble), other out_* don't-care but must be 0.
//    The same instruction is re-presented next cycle and resolves via EX/MEM forwarding.
//  - flush=1: next out_valid=0, all out_* = 0. Flush beats a stall in the same cycle.
//  - in_valid=0: behaves as a bubble; stall_out=0.
//  - stall_count increments on each cycle with stall_out=1 and saturates at all-ones (no wrap).
//  - reset asserted mid-stall: the next edge clears everything; no residual stall.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined: forwarding as above.
//  ID_EX_FORWARD_EN undefined: no forwarding; operands always come from rf_read_dataN (reg 0 still 0).
//  hz then becomes a RAW on in_rs/in_rt (nonzero) against any of:
//    * ID/EX: out_valid && out_reg_write && out_rd
//    * EX/MEM: exmem_reg_write && exmem_rd
//    * MEM/WB: memwb_reg_write && memwb_rd
//  The is_load restriction is dropped in this mode.
// TESTING
//  1 Reset: reset=1 for 2 clks with random inputs -> all out_*=0, stall_count=0, stall_out=0.
//  2 Fwd priority: rs=3; exmem(3,0x2A) and memwb(3,0x11) both valid; rf=0x05 -> out_a=0x2A next clk.
//    Drop exmem -> out_a=0x11.
//  3 Reg0: rs=0, exmem_rd=0, exmem_data=0xFF -> out_a=0x00.
//  4 Load-use: lw r4 into ID/EX, then add rs=4 -> stall_out=1 for 1 clk, bubble out_valid=0, stall_count=1.
//    Add issues next clk with out_a=exmem_data.
//  5 Flush+stall same clk: hz true, flush=1 -> stall_out=0, out_valid=0 next clk, stall_count unchanged.
//  6 Saturation (CNT_W=4): hold hazard 20 clks -> stall_count sticks at 15.
//    Without ID_EX_FORWARD_EN: memwb_rd=rs=2 -> stall_out=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// Operand fetch + ID/EX register: forwarding, load-use detection, saturating stall counter (`ID_EX_FORWARD_EN` enables forwarding).
// Latency: 1 cycle in_* -> out_*; rf_read_reg*/stall_out are combinational.
// Backpressure: stall_out holds PC and IF/ID and inserts a zeroed bubble; flush overrides a stall.
module id_ex_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_is_load,
  input  logic              in_reg_write,
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_is_load,
  output logic              out_reg_write,
  output logic [CNT_W-1:0]  stall_count
);

  logic rs_nz, rt_nz;
  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, idex_hit_a, idex_hit_b;
  logic hz;
  logic [DATA_W-1:0] op_a, op_b;

  assign rf_read_reg1 = in_rs;
  assign rf_read_reg2 = in_rt;

  assign rs_nz      = |in_rs;
  assign rt_nz      = |in_rt;
  assign ex_hit_a   = exmem_reg_write && (exmem_rd == in_rs);
  assign ex_hit_b   = exmem_reg_write && (exmem_rd == in_rt);
  assign wb_hit_a   = memwb_reg_write && (memwb_rd == in_rs);
  assign wb_hit_b   = memwb_reg_write && (memwb_rd == in_rt);
  assign idex_hit_a = out_valid && out_reg_write && (out_rd == in_rs);
  assign idex_hit_b = out_valid && out_reg_write && (out_rd == in_rt);

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB
  always_comb begin
    op_a = rf_read_data1;
    if (!rs_nz)        op_a = '0;
    else if (ex_hit_a) op_a = exmem_data;
    else if (wb_hit_a) op_a = memwb_data;
  end

  always_comb begin
    op_b = rf_read_data2;
    if (!rt_nz)        op_b = '0;
    else if (ex_hit_b) op_b = exmem_data;
    else if (wb_hit_b) op_b = memwb_data;
  end

  // Only a load in EX cannot be forwarded in time; rs/rt nonzero implies out_rd nonzero
  assign hz = in_valid && out_is_load &&
              ((rs_nz && idex_hit_a) || (rt_nz && idex_hit_b));
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{exmem_data, memwb_data};

  assign op_a = rs_nz ? rf_read_data1 : '0;
  assign op_b = rt_nz ? rf_read_data2 : '0;

  // Without bypass paths any in-flight writer of a source register must drain first
  assign hz = in_valid &&
              ((rs_nz && (idex_hit_a || ex_hit_a || wb_hit_a)) ||
               (rt_nz && (idex_hit_b || ex_hit_b || wb_hit_b)));
`endif

  assign stall_out = hz && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_a         <= '0;
      out_b         <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_ctrl      <= '0;
      out_is_load   <= 1'b0;
      out_reg_write <= 1'b0;
      stall_count   <= '0;
    end else begin
      if (stall_out && !(&stall_count))
        stall_count <= stall_count + CNT_W'(1);
      if (flush || stall_out || !in_valid) begin
        out_valid     <= 1'b0;
        out_a         <= '0;
        out_b         <= '0;
        out_imm       <= '0;
        out_rd        <= '0;
        out_ctrl      <= '0;
        out_is_load   <= 1'b0;
        out_reg_write <= 1'b0;
      end else begin
        out_valid     <= 1'b1;
        out_a         <= op_a;
        out_b         <= op_b;
        out_imm       <= in_imm;
        out_rd        <= in_rd;
        out_ctrl      <= in_ctrl;
        out_is_load   <= in_is_load;
        out_reg_write <= in_reg_write;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a transaction-level model of the ID/EX slot.
module tb_id_ex_stage;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_is_load, in_reg_write, flush;
  logic [4:0] in_rs, in_rt, in_rd, exmem_rd, memwb_rd;
  logic [7:0] in_imm, rf_read_data1, rf_read_data2, exmem_data, memwb_data;
  logic [5:0] in_ctrl;
  logic       exmem_reg_write, memwb_reg_write;
  logic [4:0] rf_read_reg1, rf_read_reg2, out_rd;
  logic       stall_out, out_valid, out_is_load, out_reg_write;
  logic [7:0] out_a, out_b, out_imm;
  logic [5:0] out_ctrl;
  logic [3:0] stall_count;

  id_ex_stage #(.DATA_W(8), .REG_AW(5), .CTRL_W(6), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_is_load(in_is_load),
    .in_reg_write(in_reg_write), .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .flush(flush), .stall_out(stall_out), .out_valid(out_valid), .out_a(out_a),
    .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .out_is_load(out_is_load), .out_reg_write(out_reg_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Instruction expected to sit in EX, plus the expected stall tally
  typedef struct packed {
    logic       v;
    logic [7:0] a, b, imm;
    logic [4:0] rd;
    logic [5:0] ctrl;
    logic       ld, rw;
  } idex_t;

  idex_t m;
  int    m_cnt;
  int    errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] operand(input logic [4:0] s, input logic [7:0] rf);
    if (s == 5'd0) return 8'h00;
`ifdef ID_EX_FORWARD_EN
    if (exmem_reg_write && exmem_rd == s) return exmem_data;
    if (memwb_reg_write && memwb_rd == s) return memwb_data;
`endif
    return rf;
  endfunction

  // Would reading register s now see a stale value that cannot be bypassed?
  function automatic bit blocked(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return m.v && m.ld && m.rw && m.rd == s;
`else
    return (m.v && m.rw && m.rd == s) ||
           (exmem_reg_write && exmem_rd == s) ||
           (memwb_reg_write && memwb_rd == s);
`endif
  endfunction

  function automatic bit model_stall();
    return in_valid && (blocked(in_rs) || blocked(in_rt)) && !flush && !reset;
  endfunction

  task automatic model_edge(input bit st);
    idex_t nxt;
    nxt = '0;
    if (reset) begin
      m = '0;
      m_cnt = 0;
    end else begin
      if (st) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      if (in_valid && !flush && !st) begin
        nxt.v    = 1'b1;
        nxt.a    = operand(in_rs, rf_read_data1);
        nxt.b    = operand(in_rt, rf_read_data2);
        nxt.imm  = in_imm;
        nxt.rd   = in_rd;
        nxt.ctrl = in_ctrl;
        nxt.ld   = in_is_load;
        nxt.rw   = in_reg_write;
      end
      m = nxt;
    end
  endtask

  // Compare process: registered outputs against the model, every cycle
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m.v));
    chk("out_a", 32'(out_a), 32'(m.a));
    chk("out_b", 32'(out_b), 32'(m.b));
    chk("out_imm", 32'(out_imm), 32'(m.imm));
    chk("out_rd", 32'(out_rd), 32'(m.rd));
    chk("out_ctrl", 32'(out_ctrl), 32'(m.ctrl));
    chk("out_is_load", 32'(out_is_load), 32'(m.ld));
    chk("out_reg_write", 32'(out_reg_write), 32'(m.rw));
    chk("stall_count", 32'(stall_count), m_cnt);
  end

  // Inputs change just after negedge; combinational outputs checked before the edge
  task automatic step();
    bit st;
    #1;
    st = model_stall();
    chk("stall_out", 32'(stall_out), 32'(st));
    chk("rf_read_reg1", 32'(rf_read_reg1), 32'(in_rs));
    chk("rf_read_reg2", 32'(rf_read_reg2), 32'(in_rt));
    @(posedge clk);
    model_edge(st);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_ctrl = 0;
    in_is_load = 0; in_reg_write = 0; rf_read_data1 = 0; rf_read_data2 = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_data = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    in_valid        = ($urandom % 4) != 0;
    in_rs           = 5'($urandom % 6);
    in_rt           = 5'($urandom % 6);
    in_rd           = 5'($urandom % 6);
    in_imm          = 8'($urandom);
    in_ctrl         = 6'($urandom);
    in_is_load      = ($urandom % 3) == 0;
    in_reg_write    = ($urandom % 4) != 0;
    rf_read_data1   = 8'($urandom);
    rf_read_data2   = 8'($urandom);
    exmem_reg_write = ($urandom % 2) == 0;
    exmem_rd        = 5'($urandom % 6);
    exmem_data      = 8'($urandom);
    memwb_reg_write = ($urandom % 2) == 0;
    memwb_rd        = 5'($urandom % 6);
    memwb_data      = 8'($urandom);
    flush           = ($urandom % 8) == 0;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic set_load_r4();
    idle();
    in_valid = 1; in_is_load = 1; in_reg_write = 1; in_rd = 5'd4;
  endtask

  task automatic set_add_uses_r4();
    idle();
    in_valid = 1; in_reg_write = 1; in_rd = 5'd5; in_rs = 5'd4; in_rt = 5'd1;
    rf_read_data1 = 8'h33; rf_read_data2 = 8'h44;
  endtask

  initial begin
    errors = 0; checks = 0; m = '0; m_cnt = 0;
    reset = 1;
    repeat (2) begin
      rand_inputs();
      step();
    end
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_a", 32'(out_a), 0);
    chk("reset_count", 32'(stall_count), 0);
    reset = 0;

    // Forwarding priority
    idle();
    in_valid = 1; in_rs = 5'd3; rf_read_data1 = 8'h05;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_data = 8'h2A;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_data = 8'h11;
    step();
`ifdef ID_EX_FORWARD_EN
    chk("fwd_exmem_a", 32'(out_a), 32'h2A);
`else
    chk("raw_exmem_bubble", 32'(out_valid), 0);
`endif
    exmem_reg_write = 0;
    step();
`ifdef ID_EX_FORWARD_EN
    chk("fwd_memwb_a", 32'(out_a), 32'h11);
`else
    chk("raw_memwb_bubble", 32'(out_valid), 0);
`endif

    // Register 0 is never forwarded
    idle();
    in_valid = 1; exmem_reg_write = 1; exmem_rd = 5'd0; exmem_data = 8'hFF;
    rf_read_data1 = 8'h9C;
    step();
    chk("reg0_valid", 32'(out_valid), 1);
    chk("reg0_a", 32'(out_a), 0);

    // Load-use: one bubble, then the dependent op takes the load result
    pulse_reset();
    set_load_r4();
    step();
    set_add_uses_r4();
    #1;
    chk("loaduse_stall", 32'(stall_out), 1);
    step();
    chk("loaduse_bubble", 32'(out_valid), 0);
    chk("loaduse_count", 32'(stall_count), 1);
    exmem_reg_write = 1; exmem_rd = 5'd4; exmem_data = 8'h77;
    step();
`ifdef ID_EX_FORWARD_EN
    chk("loaduse_issue_valid", 32'(out_valid), 1);
    chk("loaduse_issue_a", 32'(out_a), 32'h77);
`else
    chk("loaduse_raw_hold", 32'(out_valid), 0);
`endif

    // Flush beats stall
    pulse_reset();
    set_load_r4();
    step();
    set_add_uses_r4();
    flush = 1;
    #1;
    chk("flush_no_stall", 32'(stall_out), 0);
    step();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_count", 32'(stall_count), 0);

    // Saturation: 20 stalls with a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      set_load_r4();
      step();
      set_add_uses_r4();
      step();
    end
    chk("sat_count", 32'(stall_count), 15);

`ifndef ID_EX_FORWARD_EN
    idle();
    in_valid = 1; in_rs = 5'd2; memwb_reg_write = 1; memwb_rd = 5'd2;
    #1;
    chk("nofwd_memwb_stall", 32'(stall_out), 1);
    step();
`endif

    // Reset in the middle of a stall clears everything
    set_load_r4();
    step();
    set_add_uses_r4();
    reset = 1;
    #1;
    chk("reset_masks_stall", 32'(stall_out), 0);
    step();
    reset = 0;
    chk("reset_mid_count", 32'(stall_count), 0);

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      reset = ($urandom % 40) == 0;
      step();
    end

    reset = 0;
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
